// File: rtl/rsc_frame_encoder.sv
// rsc_frame_encoder: LTE constituent RSC encoder (g0=13, g1=15 octal)
// with three-word trellis termination and valid/ready on both sides.
module rsc_frame_encoder #(
    parameter int K   = 40,
    parameter int M   = 6,
    parameter int AMP = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         start_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         in_bit_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         out_b1_o,
    output logic         out_b2_o,
    output logic [M-1:0] out_ba1_o,
    output logic [M-1:0] out_ba2_o,
    output logic         out_term_o,
    output logic         out_last_o,
    output logic         busy_o,
    output logic         frame_done_o
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENC   = 2'd1;
    localparam logic [1:0] S_TERM  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [M-1:0] LLR_P = M'(AMP);
    localparam logic [M-1:0] LLR_N = M'(-AMP);
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    s_q, s_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    tcnt_q, tcnt_d;
    logic          valid_q, valid_d;
    logic          b1_q, b1_d;
    logic          b2_q, b2_d;
    logic          term_q, term_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic [M-1:0]  ba1_q, ba1_d;
    logic [M-1:0]  ba2_q, ba2_d;

    logic slot_free;
    logic out_xfer;
    logic in_rdy;
    logic a_enc;
    logic load;
    logic nb1, nb2, nterm, nlast;

    assign slot_free = !valid_q || out_ready_i;
    assign out_xfer  = en_i && valid_q && out_ready_i;
    assign in_rdy    = en_i && (state_q == S_ENC) && slot_free;
    // s_q = {s1, s2, s3}; feedback a = u ^ s2 ^ s3
    assign a_enc     = in_bit_i ^ s_q[1] ^ s_q[0];

    // Next-state: frame FSM, trellis, counters and the one-word output slot
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        valid_d = valid_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        term_d  = term_q;
        last_d  = last_q;
        done_d  = done_q;
        ba1_d   = ba1_q;
        ba2_d   = ba2_q;
        load    = 1'b0;
        nb1     = 1'b0;
        nb2     = 1'b0;
        nterm   = 1'b0;
        nlast   = 1'b0;
        if (en_i) begin
            done_d = 1'b0;
            if (out_xfer) begin
                valid_d = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_ENC;
                        s_d     = 3'b000;
                        cnt_d   = '0;
                    end
                end
                S_ENC: begin
                    if (in_valid_i && slot_free) begin
                        load  = 1'b1;
                        nb1   = in_bit_i;
                        nb2   = a_enc ^ s_q[2] ^ s_q[0];
                        s_d   = {a_enc, s_q[2], s_q[1]};
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_TERM;
                            tcnt_d  = 2'd0;
                        end
                    end
                end
                S_TERM: begin
                    if (slot_free) begin
                        load   = 1'b1;
                        nb1    = s_q[1] ^ s_q[0];
                        nb2    = s_q[2] ^ s_q[0];
                        nterm  = 1'b1;
                        nlast  = (tcnt_q == 2'd2);
                        s_d    = {1'b0, s_q[2], s_q[1]};
                        tcnt_d = tcnt_q + 2'd1;
                        if (tcnt_q == 2'd2) begin
                            state_d = S_FLUSH;
                        end
                    end
                end
                default: begin
                    if (out_xfer && last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            endcase
            if (load) begin
                valid_d = 1'b1;
                b1_d    = nb1;
                b2_d    = nb2;
                term_d  = nterm;
                last_d  = nlast;
                ba1_d   = nb1 ? LLR_N : LLR_P;
                ba2_d   = nb2 ? LLR_N : LLR_P;
            end
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            s_q     <= 3'b000;
            cnt_q   <= '0;
            tcnt_q  <= 2'd0;
            valid_q <= 1'b0;
            b1_q    <= 1'b0;
            b2_q    <= 1'b0;
            term_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ba1_q   <= '0;
            ba2_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            valid_q <= valid_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            term_q  <= term_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ba1_q   <= ba1_d;
            ba2_q   <= ba2_d;
        end
    end

    assign in_ready_o   = in_rdy;
    assign out_valid_o  = valid_q && en_i;
    assign out_b1_o     = b1_q;
    assign out_b2_o     = b2_q;
    assign out_ba1_o    = ba1_q;
    assign out_ba2_o    = ba2_q;
    assign out_term_o   = term_q;
    assign out_last_o   = last_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = done_q;

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// tb_rsc_frame_encoder: frame-level RSC model with scoreboard,
// plus hand-computed literals for impulse, zeros and K=4 termination.
module tb_rsc_frame_encoder;

    localparam int K   = 40;
    localparam int M   = 6;
    localparam int AMP = 8;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, start, in_valid, in_bit, out_ready;
    logic         in_ready, out_valid, b1, b2, term, last, busy, done;
    logic [M-1:0] ba1, ba2;

    logic         rst4, start4, in_valid4, in_bit4, out_ready4;
    logic         in_ready4, out_valid4, b14, b24, term4, last4, busy4, done4;
    logic [M-1:0] ba14, ba24;

    rsc_frame_encoder #(.K(K), .M(M), .AMP(AMP)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_bit_i(in_bit),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_b1_o(b1), .out_b2_o(b2), .out_ba1_o(ba1), .out_ba2_o(ba2),
        .out_term_o(term), .out_last_o(last), .busy_o(busy),
        .frame_done_o(done)
    );

    rsc_frame_encoder #(.K(4), .M(M), .AMP(AMP)) dut4 (
        .clk_i(clk), .rst_i(rst4), .en_i(en), .start_i(start4),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4), .in_bit_i(in_bit4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .out_b1_o(b14), .out_b2_o(b24), .out_ba1_o(ba14), .out_ba2_o(ba24),
        .out_term_o(term4), .out_last_o(last4), .busy_o(busy4),
        .frame_done_o(done4)
    );

    typedef struct packed {
        logic b1;
        logic b2;
        logic term;
        logic last;
    } word_t;

    word_t        expq[$];
    word_t        logq[$];
    int           logba1[$];
    word_t        d4q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           stall_lo = 0;
    int           stall_hi = 0;
    int           stall_cnt = 0;
    logic         pend_done = 1'b0;
    logic         stall_prev = 1'b0;
    logic [15:0]  held;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int llr(input logic b);
        return b ? -AMP : AMP;
    endfunction

    // Polynomial view: a_k = u_k ^ a_{k-2} ^ a_{k-3}, p_k = a_k ^ a_{k-1} ^ a_{k-3};
    // tail bits chosen so a_k = 0.
    function automatic void push_frame(input logic [63:0] u, input int n);
        logic  a [0:127];
        logic  ub, av, p;
        word_t w;
        for (int i = 0; i < 128; i++) a[i] = 1'b0;
        for (int k = 0; k < n + 3; k++) begin
            if (k < n) begin
                ub = u[k];
                av = ub ^ a[k+1] ^ a[k];
            end else begin
                ub = a[k+1] ^ a[k];
                av = 1'b0;
            end
            p = av ^ a[k+2] ^ a[k];
            a[k+3] = av;
            w.b1 = ub;
            w.b2 = p;
            w.term = (k >= n);
            w.last = (k == n + 2);
            expq.push_back(w);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // out_ready driver with an optional stall window
    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            out_ready = !(cyc >= stall_lo && cyc < stall_hi);
        end
    end

    // Per-cycle compare against the scoreboard
    initial begin : cmp
        word_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_done  = 1'b0;
                stall_prev = 1'b0;
            end else begin
                chk("frame_done", 32'(done), 32'(pend_done));
                pend_done = out_valid && out_ready && last;
                if (out_valid && !out_ready) begin
                    stall_cnt++;
                    chk("in_ready_stall", 32'(in_ready), 0);
                end
                if (stall_prev)
                    chk("hold_fields", 32'({b1, b2, term, last, ba1, ba2}), 32'(held));
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("extra_word", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("b1", 32'(b1), 32'(e.b1));
                        chk("b2", 32'(b2), 32'(e.b2));
                        chk("term", 32'(term), 32'(e.term));
                        chk("last", 32'(last), 32'(e.last));
                        chk("ba1", int'($signed(ba1)), llr(e.b1));
                        chk("ba2", int'($signed(ba2)), llr(e.b2));
                    end
                    logq.push_back({b1, b2, term, last});
                    logba1.push_back(int'($signed(ba1)));
                end
                stall_prev = out_valid && !out_ready;
                held = {b1, b2, term, last, ba1, ba2};
            end
        end
    end

    task automatic run_frame(input logic [63:0] u, input int n, input int abort_at);
        logic got, seen;
        logq.delete();
        logba1.delete();
        push_frame(u, n);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                tick();
                rst = 1'b0;
                expq.delete();
                chk("busy_after_reset", 32'(busy), 0);
                chk("valid_after_reset", 32'(out_valid), 0);
                chk("ba1_after_reset", 32'(ba1), 0);
                return;
            end
            in_valid = 1'b1;
            in_bit = u[i];
            got = 1'b0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                got = in_ready;
                tick();
            end
            if (!got) chk("in_timeout", 0, 1);
        end
        in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = done;
            tick();
        end
        chk("frame_done_seen", 32'(seen), 1);
        chk("queue_drained", expq.size(), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin : main
        int e4b1 [7] = '{1, 0, 0, 0, 1, 0, 1};
        int e4b2 [7] = '{1, 1, 1, 1, 1, 1, 1};
        logic [3:0] bits4;
        logic       seen4;
        rst = 1'b1; en = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; in_valid4 = 1'b0; in_bit4 = 1'b0;
        out_ready4 = 1'b1;

        // Test 1: reset values, start ignored while disabled
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_b1b2", 32'({b1, b2, term, last, done}), 0);
        chk("rst_llr", 32'({ba1, ba2}), 0);
        rst = 1'b0; en = 1'b0; start = 1'b1;
        tick(); tick();
        chk("en0_busy", 32'(busy), 0);
        chk("en0_in_ready", 32'(in_ready), 0);
        start = 1'b0; en = 1'b1;
        tick();
        chk("en1_busy", 32'(busy), 0);

        // Test 2: all-zero frame
        run_frame(64'h0, K, -1);
        chk("zeros_words", logq.size(), 43);
        if (logq.size() == 43) begin
            chk("zeros_w0", 32'(logq[0]), 0);
            chk("zeros_w39_term", 32'(logq[39].term), 0);
            chk("zeros_w40_term", 32'(logq[40]), 32'(4'b0010));
            chk("zeros_w42_last", 32'(logq[42]), 32'(4'b0011));
            chk("zeros_ba1", logba1[5], AMP);
        end

        // Test 3: impulse
        run_frame(64'h1, K, -1);
        if (logq.size() >= 5) begin
            chk("imp_b2", 32'({logq[0].b2, logq[1].b2, logq[2].b2,
                               logq[3].b2, logq[4].b2}), 32'(5'b11110));
            chk("imp_ba1_0", logba1[0], -AMP);
            chk("imp_ba1_1", logba1[1], AMP);
        end else begin
            chk("imp_words", logq.size(), 43);
        end

        // Test 5: five-cycle backpressure mid-frame
        stall_cnt = 0;
        stall_lo = cyc + 15;
        stall_hi = stall_lo + 5;
        run_frame(64'hA5C3_96F0_1E, K, -1);
        chk("stall_cycles", stall_cnt, 5);
        stall_lo = 0;
        stall_hi = 0;

        // Test 6: reset at word 20, then a fresh frame
        run_frame(64'hFF_0F0F_3355, K, 20);
        tick();
        run_frame(64'h3C_5A69_D2E1, K, -1);
        run_frame({$urandom, $urandom}, K, -1);

        // Test 4: K=4, input 1,0,0,0 with hand-derived termination
        rst4 = 1'b0;
        tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        bits4 = 4'b0001;
        d4q.delete();
        seen4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_bit4 = bits4[i];
            @(negedge clk);
            chk("k4_in_ready", 32'(in_ready4), 1);
            if (out_valid4) d4q.push_back({b14, b24, term4, last4});
            tick();
        end
        in_valid4 = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (out_valid4) d4q.push_back({b14, b24, term4, last4});
            if (done4) seen4 = 1'b1;
            if (t == 0) chk("k4_ba2_neg", int'($signed(ba24)), -AMP);
            tick();
        end
        chk("k4_words", d4q.size(), 7);
        if (d4q.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                chk("k4_b1", 32'(d4q[i].b1), e4b1[i]);
                chk("k4_b2", 32'(d4q[i].b2), e4b2[i]);
                chk("k4_term", 32'(d4q[i].term), 32'(i >= 4));
                chk("k4_last", 32'(d4q[i].last), 32'(i == 6));
            end
        end
        chk("k4_done", 32'(seen4), 1);
        chk("k4_busy", 32'(busy4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
